// File: rtl/gold_ring_pkg.sv
// Shared constants and the hop-field transform for the gold ring output arbiter.
package gold_ring_pkg;

    localparam int DATA_W  = 64;
    localparam int VC_BIT  = 63;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int HOP_W   = HOP_MSB - HOP_LSB + 1;

    typedef enum logic {
        REQ_RING = 1'b0,
        REQ_PE   = 1'b1
    } req_e;

    // Hop count is one-hot, so a decrement is a right shift of the field.
    function automatic logic [DATA_W-1:0] hop_shift(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        logic [HOP_W-1:0]  hop;
        r   = d;
        hop = d[HOP_MSB:HOP_LSB];
        r[HOP_MSB:HOP_LSB] = hop >> 1;
        return r;
    endfunction

endpackage

// File: rtl/gold_vc_slot.sv
// One-entry virtual-channel buffer: write sets full and captures data, clear empties it.
module gold_vc_slot
    import gold_ring_pkg::*;
(
    input  logic              clk,
    input  logic              i_srst,
    input  logic              i_wr_en,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;

    // Write and clear never target the same slot in one cycle; write wins defensively.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_wr_en) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/gold_ring_out_arb.sv
// Output-link arbiter for one ring direction: ring pass-through vs NIC injection,
// even/odd VC slots per requester, polarity-phased fill/drain with per-VC round robin.
module gold_ring_out_arb
    import gold_ring_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              ring_si,
    output logic              ring_ri,
    input  logic [DATA_W-1:0] ring_di,
    input  logic              pe_si,
    output logic              pe_ri,
    input  logic [DATA_W-1:0] pe_di,
    output logic              out_so,
    input  logic              out_ro,
    output logic [DATA_W-1:0] out_do,
    output logic              vc_err
);

    logic              r_polarity;
    logic [1:0]        r_rr;
    logic              r_out_so;
    logic [DATA_W-1:0] r_out_do;
    logic              r_vc_err;

    logic              w_fill_vc;
    logic [1:0]        w_ring_full;
    logic [1:0]        w_pe_full;
    logic [1:0]        w_ring_wr;
    logic [1:0]        w_pe_wr;
    logic [1:0]        w_ring_clr;
    logic [1:0]        w_pe_clr;
    logic [DATA_W-1:0] w_ring_data [2];
    logic [DATA_W-1:0] w_pe_data   [2];

    logic              w_ring_acc;
    logic              w_ring_bad;
    logic              w_pe_acc;
    logic              w_pe_bad;
    logic              w_cand_ring;
    logic              w_cand_pe;
    logic              w_contested;
    logic              w_grant_any;
    req_e              w_grant_src;
    logic [DATA_W-1:0] w_grant_data;

    // Inputs fill the VC opposite to polarity; the output drains the VC equal to it.
    assign w_fill_vc = ~r_polarity;

    assign ring_ri = ~w_ring_full[w_fill_vc];
    assign pe_ri   = ~w_pe_full[w_fill_vc];

    assign w_ring_acc = ring_si & ring_ri & (ring_di[VC_BIT] == w_fill_vc);
    assign w_ring_bad = ring_si & ring_ri & (ring_di[VC_BIT] != w_fill_vc);
    assign w_pe_acc   = pe_si & pe_ri & (pe_di[VC_BIT] == w_fill_vc);
    assign w_pe_bad   = pe_si & pe_ri & (pe_di[VC_BIT] != w_fill_vc);

    assign w_cand_ring = w_ring_full[r_polarity];
    assign w_cand_pe   = w_pe_full[r_polarity];
    assign w_contested = w_cand_ring & w_cand_pe;
    assign w_grant_any = out_ro & (w_cand_ring | w_cand_pe);

    always_comb begin
        w_grant_src = REQ_RING;
        if (w_cand_pe && (!w_cand_ring || r_rr[r_polarity])) begin
            w_grant_src = REQ_PE;
        end
    end

    assign w_grant_data = (w_grant_src == REQ_PE) ? w_pe_data[r_polarity]
                                                  : hop_shift(w_ring_data[r_polarity]);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            assign w_ring_wr[gi]  = w_ring_acc & (w_fill_vc == 1'(gi));
            assign w_pe_wr[gi]    = w_pe_acc & (w_fill_vc == 1'(gi));
            assign w_ring_clr[gi] = w_grant_any & (w_grant_src == REQ_RING) & (r_polarity == 1'(gi));
            assign w_pe_clr[gi]   = w_grant_any & (w_grant_src == REQ_PE) & (r_polarity == 1'(gi));

            gold_vc_slot u_ring_slot (
                .clk     (clk),
                .i_srst  (reset),
                .i_wr_en (w_ring_wr[gi]),
                .i_clr   (w_ring_clr[gi]),
                .i_data  (ring_di),
                .o_full  (w_ring_full[gi]),
                .o_data  (w_ring_data[gi])
            );

            gold_vc_slot u_pe_slot (
                .clk     (clk),
                .i_srst  (reset),
                .i_wr_en (w_pe_wr[gi]),
                .i_clr   (w_pe_clr[gi]),
                .i_data  (pe_di),
                .o_full  (w_pe_full[gi]),
                .o_data  (w_pe_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_polarity <= 1'b0;
            r_rr       <= 2'b00;
            r_out_so   <= 1'b0;
            r_out_do   <= '0;
            r_vc_err   <= 1'b0;
        end else begin
            r_polarity <= ~r_polarity;
            r_vc_err   <= w_ring_bad | w_pe_bad;
            if (w_grant_any) begin
                r_out_so <= 1'b1;
                r_out_do <= w_grant_data;
                // Only a contested grant moves the pointer: the loser is favoured next.
                if (w_contested) begin
                    r_rr[r_polarity] <= (w_grant_src == REQ_RING);
                end
            end else begin
                r_out_so <= 1'b0;
                r_out_do <= '0;
            end
        end
    end

    assign polarity = r_polarity;
    assign out_so   = r_out_so;
    assign out_do   = r_out_do;
    assign vc_err   = r_vc_err;

endmodule

// File: tb/tb_gold_ring_out_arb.sv
// Self-checking bench for gold_ring_out_arb: directed vector table, corner sequences,
// and randomized traffic against a slot/queue-level reference model.
module tb_gold_ring_out_arb;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        ring_si;
    logic        ring_ri;
    logic [63:0] ring_di;
    logic        pe_si;
    logic        pe_ri;
    logic [63:0] pe_di;
    logic        out_so;
    logic        out_ro;
    logic [63:0] out_do;
    logic        vc_err;

    int n_checks = 0;
    int n_errors = 0;

    gold_ring_out_arb dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .ring_si  (ring_si),
        .ring_ri  (ring_ri),
        .ring_di  (ring_di),
        .pe_si    (pe_si),
        .pe_ri    (pe_ri),
        .pe_di    (pe_di),
        .out_so   (out_so),
        .out_ro   (out_ro),
        .out_do   (out_do),
        .vc_err   (vc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_full/m_dat indexed [requester][vc], requester 0 = ring, 1 = pe.
    logic        m_full [2][2];
    logic [63:0] m_dat  [2][2];
    logic        m_rr   [2];
    logic        m_pol;
    logic        m_so;
    logic [63:0] m_do;
    logic        m_err;

    function automatic logic [63:0] hop_dec(input logic [63:0] d);
        logic [7:0]  h;
        logic [63:0] r;
        h = d[55:48];
        r = d;
        r[55:48] = h / 8'd2;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic rsi, input logic [63:0] rdi,
                              input logic psi, input logic [63:0] pdi, input logic ro);
        logic        p, f, cr, cp, g;
        logic        si  [2];
        logic [63:0] di  [2];
        logic        rdy [2];
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                for (int v = 0; v < 2; v++) begin
                    m_full[r][v] = 1'b0;
                    m_dat[r][v]  = '0;
                end
                m_rr[r] = 1'b0;
            end
            m_pol = 1'b0; m_so = 1'b0; m_do = '0; m_err = 1'b0;
            return;
        end
        p = m_pol;
        f = ~m_pol;
        si[0] = rsi; di[0] = rdi;
        si[1] = psi; di[1] = pdi;
        for (int r = 0; r < 2; r++) rdy[r] = !m_full[r][f];
        cr = m_full[0][p];
        cp = m_full[1][p];
        if (ro && (cr || cp)) begin
            g = (cr && cp) ? m_rr[p] : cp;
            m_so = 1'b1;
            m_do = g ? m_dat[1][p] : hop_dec(m_dat[0][p]);
            m_full[g][p] = 1'b0;
            if (cr && cp) m_rr[p] = !g;
        end else begin
            m_so = 1'b0;
            m_do = '0;
        end
        m_err = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (si[r] && rdy[r]) begin
                if (di[r][63] == f) begin
                    m_full[r][f] = 1'b1;
                    m_dat[r][f]  = di[r];
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        m_pol = ~m_pol;
    endtask

    // Drive one cycle of inputs, advance the model, and compare every output after the edge.
    task automatic cycle(input logic rst, input logic rsi, input logic [63:0] rdi,
                         input logic psi, input logic [63:0] pdi, input logic ro);
        reset = rst; ring_si = rsi; ring_di = rdi; pe_si = psi; pe_di = pdi; out_ro = ro;
        model_edge(rst, rsi, rdi, psi, pdi, ro);
        @(posedge clk);
        #1;
        check("polarity", 64'(polarity), 64'(m_pol));
        check("ring_ri",  64'(ring_ri),  64'(!m_full[0][!m_pol]));
        check("pe_ri",    64'(pe_ri),    64'(!m_full[1][!m_pol]));
        check("out_so",   64'(out_so),   64'(m_so));
        check("out_do",   out_do,        m_do);
        check("vc_err",   64'(vc_err),   64'(m_err));
        if (out_so) $display("xfer t=%0t pol=%0d data=%h", $time, !polarity, out_do);
    endtask

    task automatic idle(input logic ro);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, ro);
    endtask

    task automatic align(input logic p);
        if (m_pol != p) idle(1'b0);
    endtask

    typedef struct {
        logic        rst;
        logic        rsi;
        logic [63:0] rdi;
        logic        psi;
        logic [63:0] pdi;
        logic        ro;
        logic        e_pol;
        logic        e_rri;
        logic        e_pri;
        logic        e_so;
        logic [63:0] e_do;
        logic        e_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        reset = 1'b1; ring_si = 1'b0; ring_di = '0; pe_si = 1'b0; pe_di = '0; out_ro = 1'b0;

        // rst rsi rdi psi pdi ro | pol rri pri so do err
        vecs[0] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 64'h8080_0000_0000_00AA, 1'b0, 64'h0, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1,
                    1'b0, 1'b1, 1'b1, 1'b1, 64'h8040_0000_0000_00AA, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0000_0000_0055, 1'b1,
                    1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].rst, vecs[i].rsi, vecs[i].rdi, vecs[i].psi, vecs[i].pdi, vecs[i].ro);
            check("vec_pol", 64'(polarity), 64'(vecs[i].e_pol));
            check("vec_rri", 64'(ring_ri),  64'(vecs[i].e_rri));
            check("vec_pri", 64'(pe_ri),    64'(vecs[i].e_pri));
            check("vec_so",  64'(out_so),   64'(vecs[i].e_so));
            check("vec_do",  out_do,        vecs[i].e_do);
            check("vec_err", 64'(vc_err),   64'(vecs[i].e_err));
            $display("vec %0d: pol=%0d rri=%0d pri=%0d so=%0d do=%h err=%0d",
                     i, polarity, ring_ri, pe_ri, out_so, out_do, vc_err);
        end

        // Contention on VC 0: ring first, then pe; refill and pe wins.
        align(1'b1);
        cycle(1'b0, 1'b1, 64'h0010_0000_0000_1111, 1'b1, 64'h0020_0000_0000_2222, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check("cont1_do", out_do, 64'h0008_0000_0000_1111);
        idle(1'b1);
        idle(1'b1);
        check("cont2_do", out_do, 64'h0020_0000_0000_2222);
        cycle(1'b0, 1'b1, 64'h0001_0000_0000_3333, 1'b1, 64'h0040_0000_0000_4444, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check("cont3_do", out_do, 64'h0040_0000_0000_4444);
        idle(1'b1);
        idle(1'b1);
        check("cont4_do", out_do, 64'h0000_0000_0000_3333);

        // Back-pressure with both pe slots full; offers while not ready must be ignored.
        align(1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 64'h8000_0000_0000_0B0B, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 64'h0000_0000_0000_0A0A, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 64'h0000_0000_0000_0C0C, 1'b0);
            check("bp_pe_ri", 64'(pe_ri), 64'd0);
            check("bp_so", 64'(out_so), 64'd0);
        end
        idle(1'b1);
        check("bp_vc0", out_do, 64'h0000_0000_0000_0A0A);
        idle(1'b1);
        check("bp_vc1", out_do, 64'h8000_0000_0000_0B0B);

        // Reset in the middle of traffic with an output transfer in flight.
        align(1'b0);
        cycle(1'b0, 1'b1, 64'h8002_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0002, 1'b0);
        cycle(1'b0, 1'b1, 64'h0004_0000_0000_0003, 1'b1, 64'h0000_0000_0000_0004, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check("pre_rst_so", 64'(out_so), 64'd1);
        cycle(1'b1, 1'b1, 64'h8000_0000_0000_0009, 1'b1, 64'h8000_0000_0000_0009, 1'b1);
        check("rst_so", 64'(out_so), 64'd0);
        check("rst_pol", 64'(polarity), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("rst_empty", 64'(out_so), 64'd0);
        end
        // Round-robin pointers must be back at ring-favoured.
        align(1'b1);
        cycle(1'b0, 1'b1, 64'h0080_0000_0000_0055, 1'b1, 64'h0000_0000_0000_0066, 1'b0);
        idle(1'b1);
        check("rst_rr", out_do, 64'h0040_0000_0000_0055);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), {$urandom, $urandom},
                  ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
